tuner_ctrl_seq: RTL and testbench

Host-side sequencer for one ring tuner, sitting directly downstream of `tuner_phy` on its search and lock handshakes. On a host start it triggers a search and consumes the peak list. It selects one peak by index and drives that peak's power and tune code onto the phy's `i_cfg_pwr_peak` / `i_cfg_ring_tune_peak`. It then triggers lock and services lock-loss interrupts, reporting status and error codes to the host.

---
 rtl/tuner_ctrl_seq_if.sv | 54 +++++
 rtl/tuner_ctrl_seq.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_tuner_ctrl_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tuner_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : tuner_ctrl_seq_if
// Description : Handshake and data bundle between the tuner sequencer and
//               tuner_phy (search trigger, peak list, lock trigger, lock-loss
//               interrupt, resume, selected peak configuration).
// Revision    : 1.0 - initial release
// ============================================================================
interface tuner_ctrl_seq_if #(
    parameter int DAC_WIDTH  = 8,
    parameter int ADC_WIDTH  = 8,
    parameter int NUM_TARGET = 8
);
    localparam int c_CNT_W = $clog2(NUM_TARGET) + 1;

    logic                            search_trig_val;
    logic                            search_trig_rdy;
    logic                            search_peaks_val;
    logic                            search_peaks_rdy;
    logic [NUM_TARGET*DAC_WIDTH-1:0] ring_tune_peaks;
    logic [NUM_TARGET*ADC_WIDTH-1:0] pwr_peaks;
    logic [c_CNT_W-1:0]              peaks_cnt;
    logic                            lock_trig_val;
    logic                            lock_trig_rdy;
    logic                            lock_intr_val;
    logic                            lock_intr_rdy;
    logic                            lock_resume_val;
    logic                            lock_resume_rdy;
    logic [ADC_WIDTH-1:0]            cfg_pwr_peak;
    logic [DAC_WIDTH-1:0]            cfg_ring_tune_peak;

    // Sequencer side
    modport master (
        output search_trig_val,  input  search_trig_rdy,
        input  search_peaks_val, output search_peaks_rdy,
        input  ring_tune_peaks,  input  pwr_peaks, input peaks_cnt,
        output lock_trig_val,    input  lock_trig_rdy,
        input  lock_intr_val,    output lock_intr_rdy,
        output lock_resume_val,  input  lock_resume_rdy,
        output cfg_pwr_peak,     output cfg_ring_tune_peak
    );

    // Phy side
    modport slave (
        input  search_trig_val,  output search_trig_rdy,
        output search_peaks_val, input  search_peaks_rdy,
        output ring_tune_peaks,  output pwr_peaks, output peaks_cnt,
        input  lock_trig_val,    output lock_trig_rdy,
        output lock_intr_val,    input  lock_intr_rdy,
        input  lock_resume_val,  output lock_resume_rdy,
        input  cfg_pwr_peak,     input  cfg_ring_tune_peak
    );
endinterface
`default_nettype wire

// File: rtl/tuner_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tuner_ctrl_seq
// Description : Host-side sequencer for one ring tuner. Triggers a search,
//               picks one peak by index, drives its power/tune code to the
//               phy, triggers lock and services lock-loss interrupts.
//               Optional build macro TUNER_CTRL_RELOCK_EN: a lock-loss
//               interrupt triggers a full re-search/relock, bounded by
//               MAX_RELOCK attempts (error code 4 when exceeded).
// Revision    : 1.0 - initial release
// ============================================================================
module tuner_ctrl_seq #(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int NUM_TARGET     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RESUME_DELAY   = 16,
    parameter int MAX_RELOCK     = 3
) (
    input  wire logic                          i_clk,
    input  wire logic                          i_rst_n,
    input  wire logic                          i_start,
    input  wire logic                          i_abort,
    input  wire logic [$clog2(NUM_TARGET)-1:0] i_cfg_target_idx,
    input  wire logic [ADC_WIDTH-1:0]          i_cfg_pwr_min,
    tuner_ctrl_seq_if.master                   phy,
    output logic                               o_busy,
    output logic                               o_locked,
    output logic                               o_err,
    output logic [2:0]                         o_err_code,
    output logic [7:0]                         o_intr_cnt
);
    localparam int c_IDX_W  = $clog2(NUM_TARGET);
    localparam int c_CNT_W  = c_IDX_W + 1;
    localparam int c_WD_MAX = (TIMEOUT_CYCLES > RESUME_DELAY) ? TIMEOUT_CYCLES : RESUME_DELAY;
    localparam int c_WD_W   = $clog2(c_WD_MAX + 1);

    localparam logic [c_WD_W-1:0] c_WD_TIMEOUT_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_RESUME_LAST  = c_WD_W'(RESUME_DELAY);
    localparam logic [c_WD_W-1:0] c_WD_SAT          = {c_WD_W{1'b1}};

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_S_TRIG    = 4'd1;
    localparam logic [3:0] c_ST_S_WAIT    = 4'd2;
    localparam logic [3:0] c_ST_SELECT    = 4'd3;
    localparam logic [3:0] c_ST_L_TRIG    = 4'd4;
    localparam logic [3:0] c_ST_LOCKED    = 4'd5;
    localparam logic [3:0] c_ST_INTR_WAIT = 4'd6;
    localparam logic [3:0] c_ST_RESUME    = 4'd7;
    localparam logic [3:0] c_ST_ERR       = 4'd8;

    localparam logic [2:0] c_ERR_NONE    = 3'd0;
    localparam logic [2:0] c_ERR_NO_PEAK = 3'd1;
    localparam logic [2:0] c_ERR_LOW_PWR = 3'd2;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd3;

    logic [3:0]                      r_state;
    logic [3:0]                      w_next;
    logic [2:0]                      w_err_code;
    logic [c_WD_W-1:0]               r_wd;
    logic                            w_wd_expired;
    logic                            w_start_acc;
    logic                            w_intr_acc;
    logic [c_IDX_W-1:0]              r_target_idx;
    logic [ADC_WIDTH-1:0]            r_pwr_min;
    logic [NUM_TARGET*DAC_WIDTH-1:0] r_tune_flat;
    logic [NUM_TARGET*ADC_WIDTH-1:0] r_pwr_flat;
    logic [c_CNT_W-1:0]              r_peaks_cnt;
    logic [DAC_WIDTH-1:0]            w_tune [NUM_TARGET];
    logic [ADC_WIDTH-1:0]            w_pwr  [NUM_TARGET];
    logic [DAC_WIDTH-1:0]            w_sel_tune;
    logic [ADC_WIDTH-1:0]            w_sel_pwr;
    logic [ADC_WIDTH-1:0]            r_cfg_pwr;
    logic [DAC_WIDTH-1:0]            r_cfg_tune;
    logic                            r_lock_trig_val;
    logic                            r_err;
    logic [2:0]                      r_err_code;
    logic [7:0]                      r_intr_cnt;

    assign w_wd_expired = (r_wd == c_WD_TIMEOUT_LAST);
    assign w_start_acc  = ((r_state == c_ST_IDLE) || (r_state == c_ST_ERR)) && (w_next == c_ST_S_TRIG);
    assign w_intr_acc   = (r_state == c_ST_LOCKED) && phy.lock_intr_val && !i_abort;

    // Split the registered peak list into per-peak words
    for (genvar g = 0; g < NUM_TARGET; g++) begin : g_unpack
        assign w_tune[g] = r_tune_flat[g*DAC_WIDTH +: DAC_WIDTH];
        assign w_pwr[g]  = r_pwr_flat[g*ADC_WIDTH +: ADC_WIDTH];
    end

    assign w_sel_tune = w_tune[r_target_idx];
    assign w_sel_pwr  = w_pwr[r_target_idx];

`ifdef TUNER_CTRL_RELOCK_EN
    localparam int                c_RL_W        = $clog2(MAX_RELOCK + 2);
    localparam logic [c_RL_W-1:0] c_RL_MAX      = c_RL_W'(MAX_RELOCK);
    localparam logic [2:0]        c_ERR_RELOCK  = 3'd4;

    logic [c_RL_W-1:0] r_relock_cnt;
    logic              w_relock_over;

    // One more interrupt once the counter holds MAX_RELOCK exceeds the budget
    assign w_relock_over = (r_relock_cnt >= c_RL_MAX);

    // Relock attempts since the last host start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_relock_cnt <= '0;
        end else if (w_start_acc) begin
            r_relock_cnt <= '0;
        end else if (w_intr_acc && !w_relock_over) begin
            r_relock_cnt <= r_relock_cnt + 1'b1;
        end
    end
`else
    // MAX_RELOCK only shapes the relock build; kept so both builds share one parameter list
    if (MAX_RELOCK < 0) begin : g_relock_unused
    end
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision and the error code recorded on entry to ERR
    always_comb begin
        w_next     = r_state;
        w_err_code = c_ERR_NONE;
        case (r_state)
            c_ST_IDLE: begin
                if (i_start) w_next = c_ST_S_TRIG;
            end
            c_ST_S_TRIG: begin
                if (phy.search_trig_rdy) begin
                    w_next = c_ST_S_WAIT;
                end else if (w_wd_expired) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_ST_S_WAIT: begin
                if (phy.search_peaks_val) begin
                    w_next = c_ST_SELECT;
                end else if (w_wd_expired) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_ST_SELECT: begin
                if ({1'b0, r_target_idx} >= r_peaks_cnt) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_NO_PEAK;
                end else if (w_sel_pwr < r_pwr_min) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_LOW_PWR;
                end else begin
                    w_next = c_ST_L_TRIG;
                end
            end
            c_ST_L_TRIG: begin
                if (r_lock_trig_val && phy.lock_trig_rdy) begin
                    w_next = c_ST_LOCKED;
                end else if (w_wd_expired) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_ST_LOCKED: begin
                if (phy.lock_intr_val) begin
`ifdef TUNER_CTRL_RELOCK_EN
                    if (w_relock_over) begin
                        w_next     = c_ST_ERR;
                        w_err_code = c_ERR_RELOCK;
                    end else begin
                        w_next = c_ST_S_TRIG;
                    end
`else
                    w_next = c_ST_INTR_WAIT;
`endif
                end
            end
            c_ST_INTR_WAIT: begin
                if (r_wd == c_WD_RESUME_LAST) w_next = c_ST_RESUME;
            end
            c_ST_RESUME: begin
                if (phy.lock_resume_rdy) begin
                    w_next = c_ST_LOCKED;
                end else if (w_wd_expired) begin
                    w_next     = c_ST_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_ST_ERR: begin
                if (i_start) w_next = c_ST_S_TRIG;
            end
            default: w_next = c_ST_IDLE;
        endcase
        // Abort wins over any handshake completing in the same cycle
        if (i_abort) begin
            w_next     = c_ST_IDLE;
            w_err_code = c_ERR_NONE;
        end
    end

    // Outputs decoded from the state register or taken straight from registers
    always_comb begin
        phy.search_trig_val    = (r_state == c_ST_S_TRIG);
        phy.search_peaks_rdy   = (r_state == c_ST_S_WAIT);
        phy.lock_trig_val      = r_lock_trig_val;
        phy.lock_intr_rdy      = (r_state == c_ST_LOCKED);
        phy.lock_resume_val    = (r_state == c_ST_RESUME);
        phy.cfg_pwr_peak       = r_cfg_pwr;
        phy.cfg_ring_tune_peak = r_cfg_tune;
        o_locked               = (r_state == c_ST_LOCKED);
        o_busy                 = !((r_state == c_ST_IDLE) || (r_state == c_ST_LOCKED) ||
                                   (r_state == c_ST_ERR));
        o_err                  = r_err;
        o_err_code             = r_err_code;
        o_intr_cnt             = r_intr_cnt;
    end

    // Per-state wait counter: restarts on every state change, saturates otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else if (w_next != r_state) begin
            r_wd <= '0;
        end else if (r_wd != c_WD_SAT) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Host configuration captured when a start is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target_idx <= '0;
            r_pwr_min    <= '0;
        end else if (w_start_acc) begin
            r_target_idx <= i_cfg_target_idx;
            r_pwr_min    <= i_cfg_pwr_min;
        end
    end

    // Peak list captured on an accepted (non-aborted) peak handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tune_flat <= '0;
            r_pwr_flat  <= '0;
            r_peaks_cnt <= '0;
        end else if ((r_state == c_ST_S_WAIT) && (w_next == c_ST_SELECT)) begin
            r_tune_flat <= phy.ring_tune_peaks;
            r_pwr_flat  <= phy.pwr_peaks;
            r_peaks_cnt <= phy.peaks_cnt;
        end
    end

    // Selected peak loaded when SELECT passes; held through abort and errors
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_pwr  <= '0;
            r_cfg_tune <= '0;
        end else if ((r_state == c_ST_SELECT) && (w_next == c_ST_L_TRIG)) begin
            r_cfg_pwr  <= w_sel_pwr;
            r_cfg_tune <= w_sel_tune;
        end
    end

    // Lock trigger rises one cycle into L_TRIG so cfg is already settled at the phy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_trig_val <= 1'b0;
        end else begin
            r_lock_trig_val <= (r_state == c_ST_L_TRIG) && (w_next == c_ST_L_TRIG);
        end
    end

    // Sticky error flag and code, cleared by an accepted start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else if (w_start_acc) begin
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else if ((w_next == c_ST_ERR) && (r_state != c_ST_ERR)) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
        end
    end

    // Saturating count of serviced lock-loss interrupts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_intr_cnt <= '0;
        end else if (w_intr_acc && (r_intr_cnt != 8'hFF)) begin
            r_intr_cnt <= r_intr_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tuner_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tuner_ctrl_seq
// Description : Self-checking bench for tuner_ctrl_seq: directed corner cases
//               plus randomized peak lists, scoreboard-checked outcomes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tuner_ctrl_seq;
    localparam int c_DAC = 8;
    localparam int c_ADC = 8;
    localparam int c_NT  = 8;
    localparam int c_TO  = 64;
    localparam int c_RD  = 16;
    localparam int c_MR  = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] tidx  = '0;
    logic [7:0] pmin  = '0;
    logic       busy, locked, err;
    logic [2:0] err_code;
    logic [7:0] intr_cnt;

    tuner_ctrl_seq_if #(.DAC_WIDTH(c_DAC), .ADC_WIDTH(c_ADC), .NUM_TARGET(c_NT)) phy();

    tuner_ctrl_seq #(
        .DAC_WIDTH(c_DAC), .ADC_WIDTH(c_ADC), .NUM_TARGET(c_NT),
        .TIMEOUT_CYCLES(c_TO), .RESUME_DELAY(c_RD), .MAX_RELOCK(c_MR)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_cfg_target_idx(tidx), .i_cfg_pwr_min(pmin), .phy(phy),
        .o_busy(busy), .o_locked(locked), .o_err(err), .o_err_code(err_code),
        .o_intr_cnt(intr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int tune; int pwr; } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_pw[8];
    logic [7:0] m_tn[8];
    int         m_cnt;
    int         cur_idx, cur_pm;
    int         model_intr   = 0;
    int         model_relock = 0;
    int         last_tune    = 0;
    int         last_pwr     = 0;
    logic       mon_prev_err = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference outcome of one search, straight from the selection rules
    function automatic exp_t predict(input int idx, input int pm);
        exp_t e;
        e.tune = 0;
        e.pwr  = 0;
        if (idx >= m_cnt)          e.code = 1;
        else if (int'(m_pw[idx]) < pm) e.code = 2;
        else begin
            e.code = 0;
            e.tune = m_tn[idx];
            e.pwr  = m_pw[idx];
        end
        return e;
    endfunction

    task automatic sb_pop(input int code, input int tune, input int pwr);
        exp_t e;
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_code", code, e.code);
            if (e.code == 0) begin
                check("sb_tune", tune, e.tune);
                check("sb_pwr", pwr, e.pwr);
            end
        end
    endtask

    // Monitor: lock-trigger handshakes and error entries are the DUT's outcomes
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_err = 1'b0;
            end else begin
                if (phy.lock_trig_val && phy.lock_trig_rdy)
                    sb_pop(0, phy.cfg_ring_tune_peak, phy.cfg_pwr_peak);
                if (err && !mon_prev_err)
                    sb_pop(err_code, 0, 0);
                mon_prev_err = err;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check_reset_vals();
        check("rst_strig", phy.search_trig_val, 0);
        check("rst_prdy", phy.search_peaks_rdy, 0);
        check("rst_ltrig", phy.lock_trig_val, 0);
        check("rst_irdy", phy.lock_intr_rdy, 0);
        check("rst_resume", phy.lock_resume_val, 0);
        check("rst_cfg_pwr", phy.cfg_pwr_peak, 0);
        check("rst_cfg_tune", phy.cfg_ring_tune_peak, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_intr", intr_cnt, 0);
    endtask

    task automatic rand_peaks();
        m_cnt = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
            m_pw[i] = 8'($urandom);
            m_tn[i] = 8'($urandom);
        end
    endtask

    task automatic nominal_peaks();
        m_cnt = 4;
        m_pw[0] = 10; m_pw[1] = 40; m_pw[2] = 80;  m_pw[3] = 20;
        m_tn[0] = 5;  m_tn[1] = 30; m_tn[2] = 90;  m_tn[3] = 140;
        for (int i = 4; i < 8; i++) begin
            m_pw[i] = 8'($urandom);
            m_tn[i] = 8'($urandom);
        end
    endtask

    task automatic drive_peaks();
        for (int i = 0; i < 8; i++) begin
            phy.pwr_peaks[i*8 +: 8]       = m_pw[i];
            phy.ring_tune_peaks[i*8 +: 8] = m_tn[i];
        end
        phy.peaks_cnt = 4'(m_cnt);
    endtask

    task automatic do_start(input int idx, input int pm);
        cur_idx = idx;
        cur_pm  = pm;
        model_relock = 0;
        tidx  = idx[2:0];
        pmin  = pm[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_to_trig", phy.search_trig_val, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic trig_handshake();
        int d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            check("strig_hold", phy.search_trig_val, 1);
            tick();
        end
        phy.search_trig_rdy = 1'b1;
        tick();
        phy.search_trig_rdy = 1'b0;
        check("peaks_rdy", phy.search_peaks_rdy, 1);
    endtask

    task automatic serve_search();
        int d;
        trig_handshake();
        d = $urandom_range(0, 3);
        repeat (d) tick();
        drive_peaks();
        phy.search_peaks_val = 1'b1;
        tick();
        phy.search_peaks_val = 1'b0;
    endtask

    // Called one cycle after the peak accept edge
    task automatic finish_txn(input exp_t e);
        int d;
        tick();
        if (e.code == 0) begin
            check("cfg_tune", phy.cfg_ring_tune_peak, e.tune);
            check("cfg_pwr", phy.cfg_pwr_peak, e.pwr);
            check("ltrig_after_cfg", phy.lock_trig_val, 0);
            tick();
            check("ltrig_raised", phy.lock_trig_val, 1);
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                tick();
                check("ltrig_hold", phy.lock_trig_val, 1);
            end
            phy.lock_trig_rdy = 1'b1;
            tick();
            phy.lock_trig_rdy = 1'b0;
            check("locked", locked, 1);
            check("locked_busy", busy, 0);
            last_tune = e.tune;
            last_pwr  = e.pwr;
        end else begin
            check("err_set", err, 1);
            check("err_code", err_code, e.code);
            check("err_no_ltrig", phy.lock_trig_val, 0);
            check("err_cfg_hold", phy.cfg_ring_tune_peak, last_tune);
        end
    endtask

    task automatic run_txn(input int idx, input int pm);
        exp_t e = predict(idx, pm);
        sb_q.push_back(e);
        do_start(idx, pm);
        serve_search();
        finish_txn(e);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_locked", locked, 0);
    endtask

    task automatic do_intr();
        int k;
        int d;
        check("intr_rdy", phy.lock_intr_rdy, 1);
        phy.lock_intr_val = 1'b1;
        tick();
        phy.lock_intr_val = 1'b0;
        if (model_intr < 255) model_intr++;
        check("intr_cnt", intr_cnt, model_intr);
`ifdef TUNER_CTRL_RELOCK_EN
        model_relock++;
        if (model_relock > c_MR) begin
            sb_q.push_back('{4, 0, 0});
            check("relock_err", err, 1);
            check("relock_code", err_code, 4);
        end else begin
            exp_t e = predict(cur_idx, cur_pm);
            sb_q.push_back(e);
            check("relock_strig", phy.search_trig_val, 1);
            serve_search();
            finish_txn(e);
        end
`else
        k = 0;
        while (!phy.lock_resume_val && k < 200) begin
            tick();
            k++;
        end
        check("resume_latency", k, c_RD + 1);
        check("resume_busy", busy, 1);
        d = $urandom_range(0, 3);
        repeat (d) tick();
        phy.lock_resume_rdy = 1'b1;
        tick();
        phy.lock_resume_rdy = 1'b0;
        check("resume_locked", locked, 1);
`endif
    endtask

    initial begin
        int k;
        phy.search_trig_rdy  = 1'b0;
        phy.search_peaks_val = 1'b0;
        phy.ring_tune_peaks  = '0;
        phy.pwr_peaks        = '0;
        phy.peaks_cnt        = '0;
        phy.lock_trig_rdy    = 1'b0;
        phy.lock_intr_val    = 1'b0;
        phy.lock_resume_rdy  = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Nominal lock on peak 2
        nominal_peaks();
        run_txn(2, 50);
        do_intr();
        do_abort();
        check("abort_cfg_hold", phy.cfg_pwr_peak, last_pwr);

        // Index past the reported count
        nominal_peaks();
        m_cnt = 3;
        run_txn(5, 0);

        // Selected peak too weak
        nominal_peaks();
        run_txn(0, 50);

        // Search trigger never accepted
        sb_q.push_back('{3, 0, 0});
        do_start(1, 0);
        k = 0;
        while (!err && k < 1000) begin
            tick();
            k++;
        end
        check("timeout_latency", k, c_TO);
        check("timeout_code", err_code, 3);

        // Abort coincident with the peak handshake discards the peaks
        rand_peaks();
        do_start(0, 0);
        trig_handshake();
        drive_peaks();
        phy.search_peaks_val = 1'b1;
        abort = 1'b1;
        tick();
        phy.search_peaks_val = 1'b0;
        abort = 1'b0;
        check("abortw_busy", busy, 0);
        check("abortw_prdy", phy.search_peaks_rdy, 0);
        check("abortw_cfg", phy.cfg_ring_tune_peak, last_tune);
        repeat (3) tick();
        check("abortw_idle", phy.search_trig_val | phy.lock_trig_val, 0);

        // Randomized peak lists and selection settings
        for (int n = 0; n < 30; n++) begin
            rand_peaks();
            run_txn($urandom_range(0, 7), $urandom_range(0, 255));
            if (locked) begin
                if ($urandom_range(0, 1) == 1) do_intr();
                do_abort();
            end
        end

`ifdef TUNER_CTRL_RELOCK_EN
        nominal_peaks();
        run_txn(2, 50);
        for (int n = 0; n < 4; n++) do_intr();
`endif

        // Asynchronous reset mid-operation
        nominal_peaks();
        run_txn(2, 50);
`ifndef TUNER_CTRL_RELOCK_EN
        phy.lock_intr_val = 1'b1;
        tick();
        phy.lock_intr_val = 1'b0;
        k = 0;
        while (!phy.lock_resume_val && k < 200) begin
            tick();
            k++;
        end
        check("pre_rst_resume", phy.lock_resume_val, 1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_intr = 0;
        last_tune  = 0;
        last_pwr   = 0;
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        check("no_restart", phy.search_trig_val | busy, 0);

`ifndef TUNER_CTRL_RELOCK_EN
        // Interrupt counter saturation
        nominal_peaks();
        run_txn(2, 50);
        for (int n = 0; n < 256; n++) do_intr();
        check("intr_sat", intr_cnt, 255);
`endif

        repeat (4) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
